// File: rtl/alu_ctrl_pkg.sv
// Shared control codes, aluOp encodings and sequencer state for the ALU control path.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package alu_ctrl_pkg;

    localparam int ALU_ADD  = 0;
    localparam int ALU_SUB  = 1;
    localparam int ALU_SLL  = 6;
    localparam int ALU_SRL  = 7;
    localparam int ALU_OP8  = 8;
    localparam int NOP_CODE = 15;

    localparam int OP_ADD   = 0;
    localparam int OP_SUB   = 1;
    localparam int OP_RTYPE = 2;
    localparam int OP_SHIFT = 3;
    localparam int OP_IMM   = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } seqState_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational aluOp/func/shiftDirection to ALU control code decoder.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the sequencing top decides when the result is used.
module alu_ctrl_decode #(
    parameter int OP_W   = 3,
    parameter int FUNC_W = 3,
    parameter int CTRL_W = 4,
    parameter logic [CTRL_W-1:0] NOP_CODE = 4'd15
) (
    input  logic [OP_W-1:0]   aluOp,
    input  logic [FUNC_W-1:0] func,
    input  logic              shiftDirection,
    output logic [CTRL_W-1:0] code,
    output logic              isShift,
    output logic              illegal
);
    import alu_ctrl_pkg::*;

    always_comb begin
        code    = NOP_CODE;
        isShift = 1'b0;
        illegal = 1'b0;
        case (aluOp)
            OP_W'(OP_ADD):   code = CTRL_W'(ALU_ADD);
            OP_W'(OP_SUB):   code = CTRL_W'(ALU_SUB);
            OP_W'(OP_RTYPE): code = CTRL_W'(func);
            OP_W'(OP_IMM):   code = CTRL_W'(ALU_OP8);
            OP_W'(OP_SHIFT): begin
                isShift = 1'b1;
                code    = shiftDirection ? CTRL_W'(ALU_SLL) : CTRL_W'(ALU_SRL);
            end
            // Every encoding above OP_IMM is reserved.
            default:         illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_control_seq.sv
// Registered ALU control sequencer: decodes ops and expands N-bit shifts into N single-bit steps.
// Latency: 1 cycle from accept to first aluControl; shifts then emit one step per unstalled cycle.
// Backpressure: opReady only in IDLE without stall; stall freezes every register.
module alu_control_seq #(
    parameter int OP_W    = 3,
    parameter int FUNC_W  = 3,
    parameter int CTRL_W  = 4,
    parameter int SHAMT_W = 4,
    parameter logic [CTRL_W-1:0] NOP_CODE = 4'd15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               opValid,
    output logic               opReady,
    input  logic [OP_W-1:0]    aluOp,
    input  logic [FUNC_W-1:0]  func,
    input  logic               shiftDirection,
    input  logic [SHAMT_W-1:0] shiftAmount,
    input  logic               stall,
    output logic [CTRL_W-1:0]  aluControl,
    output logic               ctrlValid,
    output logic               ctrlLast,
    output logic               illegalOp,
    output logic               busy
);
    import alu_ctrl_pkg::*;

    seqState_t          state, stateNxt;
    logic [SHAMT_W-1:0] remaining, remainingNxt;
    logic [CTRL_W-1:0]  shiftCode, shiftCodeNxt;
    logic [CTRL_W-1:0]  aluControlNxt;
    logic               ctrlValidNxt, ctrlLastNxt, illegalOpNxt;

    logic [CTRL_W-1:0]  decCode;
    logic               decIsShift, decIllegal;
    logic               accept;

    alu_ctrl_decode #(
        .OP_W     (OP_W),
        .FUNC_W   (FUNC_W),
        .CTRL_W   (CTRL_W),
        .NOP_CODE (NOP_CODE)
    ) u_decode (
        .aluOp          (aluOp),
        .func           (func),
        .shiftDirection (shiftDirection),
        .code           (decCode),
        .isShift        (decIsShift),
        .illegal        (decIllegal)
    );

    assign opReady = (state == IDLE) && !stall;
    assign busy    = (state == SHIFT);
    assign accept  = opValid && opReady;

    always_comb begin
        stateNxt      = state;
        remainingNxt  = remaining;
        shiftCodeNxt  = shiftCode;
        aluControlNxt = aluControl;
        ctrlValidNxt  = ctrlValid;
        ctrlLastNxt   = ctrlLast;
        illegalOpNxt  = illegalOp;
        if (!stall) begin
            case (state)
                IDLE: begin
                    ctrlValidNxt = 1'b0;
                    ctrlLastNxt  = 1'b0;
                    illegalOpNxt = 1'b0;
                    if (accept) begin
                        ctrlValidNxt  = 1'b1;
                        ctrlLastNxt   = 1'b1;
                        aluControlNxt = decCode;
                        illegalOpNxt  = decIllegal;
                        if (decIsShift) begin
                            if (shiftAmount == '0) begin
                                aluControlNxt = NOP_CODE;
                            end else begin
                                // First step goes out with the accept; the rest come from SHIFT.
                                shiftCodeNxt = decCode;
                                remainingNxt = shiftAmount - SHAMT_W'(1);
                                ctrlLastNxt  = (shiftAmount == SHAMT_W'(1));
                                if (shiftAmount > SHAMT_W'(1)) begin
                                    stateNxt = SHIFT;
                                end
                            end
                        end
                    end
                end
                SHIFT: begin
                    // remaining is at least 1 here, so the decrement never wraps.
                    ctrlValidNxt  = 1'b1;
                    illegalOpNxt  = 1'b0;
                    aluControlNxt = shiftCode;
                    ctrlLastNxt   = (remaining == SHAMT_W'(1));
                    remainingNxt  = remaining - SHAMT_W'(1);
                    if (remaining == SHAMT_W'(1)) begin
                        stateNxt = IDLE;
                    end
                end
                default: stateNxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            remaining  <= '0;
            shiftCode  <= CTRL_W'(ALU_SRL);
            aluControl <= NOP_CODE;
            ctrlValid  <= 1'b0;
            ctrlLast   <= 1'b0;
            illegalOp  <= 1'b0;
        end else begin
            state      <= stateNxt;
            remaining  <= remainingNxt;
            shiftCode  <= shiftCodeNxt;
            aluControl <= aluControlNxt;
            ctrlValid  <= ctrlValidNxt;
            ctrlLast   <= ctrlLastNxt;
            illegalOp  <= illegalOpNxt;
        end
    end

endmodule

// File: tb/tb_alu_control_seq.sv
// Bench for alu_control_seq: decode table, hand-written shift/stall/reset sequences, random vs reference model.
module tb_alu_control_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       opValid = 1'b0;
    logic       opReady;
    logic [2:0] aluOp = '0;
    logic [2:0] func = '0;
    logic       shiftDirection = 1'b0;
    logic [3:0] shiftAmount = '0;
    logic       stall = 1'b0;
    logic [3:0] aluControl;
    logic       ctrlValid, ctrlLast, illegalOp, busy;

    int errors = 0;
    int checks = 0;

    alu_control_seq #(
        .OP_W(3), .FUNC_W(3), .CTRL_W(4), .SHAMT_W(4), .NOP_CODE(4'd15)
    ) dut (
        .clk(clk), .rst_n(rst_n), .opValid(opValid), .opReady(opReady),
        .aluOp(aluOp), .func(func), .shiftDirection(shiftDirection),
        .shiftAmount(shiftAmount), .stall(stall), .aluControl(aluControl),
        .ctrlValid(ctrlValid), .ctrlLast(ctrlLast), .illegalOp(illegalOp), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int op; int fn; int dir; int amt;
        int expCode; int expLast; int expIll;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input int op, input int fn, input int dir, input int amt);
        opValid        = 1'b1;
        aluOp          = 3'(op);
        func           = 3'(fn);
        shiftDirection = dir[0];
        shiftAmount    = 4'(amt);
    endtask

    task automatic chkOut(input string name, input int code, input int vld, input int last, input int ill);
        chk({name, "_code"}, int'(aluControl), code);
        chk({name, "_valid"}, int'(ctrlValid), vld);
        chk({name, "_last"}, int'(ctrlLast), last);
        chk({name, "_ill"}, int'(illegalOp), ill);
    endtask

    // Reference model state: what the outputs must be after the next edge.
    int mRem = 0, mShiftCode = 7, mCode = 15, mValid = 0, mLast = 0, mIll = 0;
    int lastCount;

    initial begin
        vecs[0]  = '{0, 0, 0, 0,  0, 1, 0};
        vecs[1]  = '{1, 3, 1, 0,  1, 1, 0};
        vecs[2]  = '{2, 5, 0, 0,  5, 1, 0};
        vecs[3]  = '{2, 0, 1, 0,  0, 1, 0};
        vecs[4]  = '{2, 7, 0, 0,  7, 1, 0};
        vecs[5]  = '{4, 2, 0, 9,  8, 1, 0};
        vecs[6]  = '{3, 0, 1, 0, 15, 1, 0};
        vecs[7]  = '{3, 0, 1, 1,  6, 1, 0};
        vecs[8]  = '{3, 4, 0, 1,  7, 1, 0};
        vecs[9]  = '{5, 0, 0, 0, 15, 1, 1};
        vecs[10] = '{6, 1, 1, 0, 15, 1, 1};
        vecs[11] = '{7, 0, 0, 3, 15, 1, 1};

        // Reset state
        repeat (2) @(negedge clk);
        chkOut("reset", 15, 0, 0, 0);
        chk("reset_busy", int'(busy), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single-cycle decode table, each followed by an idle cycle
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].op, vecs[i].fn, vecs[i].dir, vecs[i].amt);
            #1 chk("tbl_ready", int'(opReady), 1);
            @(negedge clk);
            chkOut("tbl", vecs[i].expCode, 1, vecs[i].expLast, vecs[i].expIll);
            chk("tbl_busy", int'(busy), 0);
            opValid = 1'b0;
            @(negedge clk);
            chkOut("tbl_idle", vecs[i].expCode, 0, 0, 0);
        end

        // Four-step right shift
        drive(3, 0, 0, 4);
        @(negedge clk);
        opValid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            if (k > 1) @(negedge clk);
            chkOut("shift4", 7, 1, (k == 4) ? 1 : 0, 0);
            chk("shift4_busy", int'(busy), (k < 4) ? 1 : 0);
            chk("shift4_ready", int'(opReady), (k < 4) ? 0 : 1);
        end
        @(negedge clk);
        chkOut("shift4_idle", 7, 0, 0, 0);

        // Stall after step 1 of a three-step left shift
        drive(3, 0, 1, 3);
        @(negedge clk);
        opValid = 1'b0;
        chkOut("stall_s1", 6, 1, 0, 0);
        lastCount = int'(ctrlLast);
        stall = 1'b1;
        for (int s = 0; s < 2; s++) begin
            @(negedge clk);
            chkOut("stall_hold", 6, 1, 0, 0);
            chk("stall_busy", int'(busy), 1);
            chk("stall_ready", int'(opReady), 0);
            lastCount += int'(ctrlLast);
        end
        stall = 1'b0;
        @(negedge clk);
        chkOut("stall_s2", 6, 1, 0, 0);
        lastCount += int'(ctrlLast);
        @(negedge clk);
        chkOut("stall_s3", 6, 1, 1, 0);
        lastCount += int'(ctrlLast);
        @(negedge clk);
        chkOut("stall_idle", 6, 0, 0, 0);
        lastCount += int'(ctrlLast);
        chk("stall_last_pulses", lastCount, 1);

        // Back-to-back: shift of 2 then SUB held valid, no bubble
        drive(3, 0, 1, 2);
        @(negedge clk);
        chkOut("b2b_s1", 6, 1, 0, 0);
        drive(1, 0, 0, 0);
        #1 chk("b2b_ready_busy", int'(opReady), 0);
        @(negedge clk);
        chkOut("b2b_s2", 6, 1, 1, 0);
        chk("b2b_ready", int'(opReady), 1);
        @(negedge clk);
        chkOut("b2b_sub", 1, 1, 1, 0);
        opValid = 1'b0;
        @(negedge clk);

        // Reset in the middle of a five-step shift
        drive(3, 0, 1, 5);
        @(negedge clk);
        opValid = 1'b0;
        chkOut("rst_s1", 6, 1, 0, 0);
        @(negedge clk);
        chkOut("rst_s2", 6, 1, 0, 0);
        rst_n = 1'b0;
        #1;
        chkOut("rst_now", 15, 0, 0, 0);
        chk("rst_busy", int'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("rst_after_valid", int'(ctrlValid), 0);
            chk("rst_after_busy", int'(busy), 0);
        end

        // Random traffic against the reference model
        mRem = 0; mCode = 15; mValid = 0; mLast = 0; mIll = 0;
        for (int c = 0; c < 1500; c++) begin
            stall          = ($urandom_range(0, 3) == 0);
            opValid        = $urandom_range(0, 1) == 1;
            aluOp          = 3'($urandom_range(0, 7));
            func           = 3'($urandom_range(0, 7));
            shiftDirection = $urandom_range(0, 1) == 1;
            shiftAmount    = 4'($urandom_range(0, 15));
            #1 chk("rnd_ready", int'(opReady), (mRem == 0 && !stall) ? 1 : 0);
            if (!stall) begin
                if (mRem > 0) begin
                    mValid = 1; mIll = 0;
                    mCode  = mShiftCode;
                    mLast  = (mRem == 1);
                    mRem   = mRem - 1;
                end else if (opValid) begin
                    mValid = 1; mLast = 1;
                    mIll   = (aluOp >= 5);
                    case (int'(aluOp))
                        0: mCode = 0;
                        1: mCode = 1;
                        2: mCode = int'(func);
                        4: mCode = 8;
                        3: begin
                            if (shiftAmount == 0) begin
                                mCode = 15;
                            end else begin
                                mShiftCode = shiftDirection ? 6 : 7;
                                mCode = mShiftCode;
                                mLast = (shiftAmount == 1);
                                mRem  = int'(shiftAmount) - 1;
                            end
                        end
                        default: mCode = 15;
                    endcase
                end else begin
                    mValid = 0; mLast = 0; mIll = 0;
                end
            end
            @(negedge clk);
            chkOut("rnd", mCode, mValid, mLast, mIll);
            chk("rnd_busy", int'(busy), (mRem > 0) ? 1 : 0);
        end
        opValid = 1'b0;
        stall = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_control_seq.md
Name: alu_control_seq

Overview:
- Parametrised, registered successor to the combinational ALU control decoder.
- Decodes aluOp/func/shiftDirection into an ALU control code through a valid/ready handshake.
- Sequences multi-bit shifts as N consecutive single-bit shift steps, driven by an internal counter and FSM.
- Sits between the main control unit and the ALU. Adds stall, illegal-op flagging, and a last-step marker for the datapath.

Parameters:
- OP_W, 3, aluOp width.
- FUNC_W, 3, func field width (must be ≤ CTRL_W-1).
- CTRL_W, 4, aluControl width.
- SHAMT_W, 4, shiftAmount width (max shift 2^SHAMT_W-1).
- NOP_CODE, 4'd15, control code meaning "ALU idle/no-op".

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- opValid  input  1  request present.
- opReady  output  1  block can accept; combinational = (state==IDLE) && !stall.
- aluOp  input  OP_W  operation class.
- func  input  FUNC_W  R-type function field.
- shiftDirection  input  1  1 = left (code 6), 0 = right (code 7).
- shiftAmount  input  SHAMT_W  shift distance in bits.
- stall  input  1  freeze all state and outputs.
- aluControl  output  CTRL_W  registered control code.
- ctrlValid  output  1  aluControl valid this cycle.
- ctrlLast  output  1  final step of the current operation.
- illegalOp  output  1  one-cycle flag: aluOp ≥ 5 accepted.
- busy  output  1  state==SHIFT.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, remaining=0.
  - aluControl=NOP_CODE.
  - ctrlValid=0, ctrlLast=0, illegalOp=0, busy=0.
  - Effect is immediate. A shift in progress is abandoned and no further steps are issued.
- Accept: rising edge with opValid && opReady. Inputs are sampled at that edge. Outputs are registered, so latency is 1 cycle.
- Decode on accept, with ctrlValid=1 in every case:
  - aluOp=0: aluControl=0, ctrlLast=1.
  - aluOp=1: aluControl=1, ctrlLast=1.
  - aluOp=2: aluControl={0, func}, zero-extended to CTRL_W; ctrlLast=1.
  - aluOp=4: aluControl=8, ctrlLast=1.
  - aluOp=3, shiftAmount=0: aluControl=NOP_CODE, ctrlLast=1, state stays IDLE.
  - aluOp=3, shiftAmount=N≥1: aluControl=6 or 7 per shiftDirection, ctrlLast=(N==1), remaining=N-1. State goes to SHIFT if N>1, else stays IDLE.
  - aluOp 5..7: aluControl=NOP_CODE, ctrlLast=1, illegalOp=1 for one cycle.
- SHIFT state, each edge with !stall:
  - Re-emit the latched shift code with ctrlValid=1 and ctrlLast=(remaining==1).
  - Decrement remaining.
  - When remaining was 1, return to IDLE.
  - Direction is latched at accept; shiftDirection changes during SHIFT are ignored.
- Step count: an N-bit shift yields exactly N consecutive ctrlValid cycles (no stalls), with ctrlLast only on the Nth.
- Back-to-back: during the cycle the final step is presented, state is already IDLE, so opReady=1 and a new op can be accepted with no bubble.
- Idle cycle with no accept:
  - ctrlValid, ctrlLast and illegalOp deassert to 0.
  - aluControl holds its last value.
- Stall:
  - Every register holds, including ctrlValid, ctrlLast, illegalOp and remaining.
  - opReady=0, so no accept.
  - Stall asserted mid-shift extends the sequence without losing or duplicating steps.
- opValid while busy: ignored; the requester must hold it until opReady.
- Width rule: remaining is SHAMT_W bits and never underflows. The maximum shift is 2^SHAMT_W-1 steps.

Decomposition:
- Shared package alu_ctrl_pkg holds:
  - Control codes: ALU_ADD=0, ALU_SUB=1, ALU_SLL=6, ALU_SRL=7, ALU_OP8=8, NOP_CODE=15.
  - aluOp encodings: OP_ADD=0, OP_SUB=1, OP_RTYPE=2, OP_SHIFT=3, OP_IMM=4.
  - FSM state typedef: IDLE, SHIFT.
- One natural sub-module, alu_ctrl_decode: purely combinational aluOp/func/shiftDirection → code + illegal flag. It is instantiated by the sequencing top.

Test Plan:
1. Reset mid-shift: accept aluOp=3, dir=1, amt=5; assert rst_n=0 after 2 valid steps → outputs immediately NOP_CODE/0/0. After release, no further steps are issued.
2. R-type: aluOp=2, func=3'b101 accepted → next cycle aluControl=4'd5, ctrlValid=1, ctrlLast=1. Following idle cycle: ctrlValid=0, aluControl stays 5.
3. Shift sequence: aluOp=3, dir=0, amt=4 → 4 consecutive cycles aluControl=7, ctrlValid=1; ctrlLast only on the 4th. busy=1 for cycles 1–3; opReady=0 during busy.
4. Stall mid-shift: amt=3, stall=1 for 2 cycles after step 1 → step 1 outputs held 2 extra cycles, then steps 2 and 3. Total ctrlLast pulses=1.
5. Edge cases: amt=0 → single cycle aluControl=15, ctrlLast=1. aluOp=6 → aluControl=15, illegalOp=1 for exactly one cycle.
6. Back-to-back: shift amt=2 followed immediately by aluOp=1 held valid → aluControl sequence 6,6,1 on consecutive cycles with no bubble.
